// File: rtl/mi_rr_arbiter.sv
// Round-robin arbiter sharing one MI slave port among several MI masters.
// Read responses are routed back in order through a small ID FIFO.
module mi_rr_arbiter #(
    parameter int MASTERS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic [MASTERS*DATA_WIDTH-1:0]  RX_MI_DWR,
    input  logic [MASTERS*ADDR_WIDTH-1:0]  RX_MI_ADDR,
    input  logic [MASTERS*DATA_WIDTH/8-1:0] RX_MI_BE,
    input  logic [MASTERS-1:0]             RX_MI_RD,
    input  logic [MASTERS-1:0]             RX_MI_WR,
    output logic [MASTERS-1:0]             RX_MI_ARDY,
    output logic [DATA_WIDTH-1:0]          RX_MI_DRD,
    output logic [MASTERS-1:0]             RX_MI_DRDY,
    output logic [DATA_WIDTH-1:0]          TX_MI_DWR,
    output logic [ADDR_WIDTH-1:0]          TX_MI_ADDR,
    output logic [DATA_WIDTH/8-1:0]        TX_MI_BE,
    output logic                           TX_MI_RD,
    output logic                           TX_MI_WR,
    input  logic                           TX_MI_ARDY,
    input  logic [DATA_WIDTH-1:0]          TX_MI_DRD,
    input  logic                           TX_MI_DRDY,
    output logic                           ERR_UNEXP_DRDY
);

    localparam int IW = $clog2(MASTERS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q;

    logic [MASTERS-1:0] req;
    logic            busy, fifo_full, fifo_empty;
    logic            g_rd, g_wr, accept, push, pop, found;
    logic [IW-1:0]   head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req        = RX_MI_RD | RX_MI_WR;
    assign busy       = (state_q == BUSY);
    assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_q];

    always_comb begin
        g_rd       = 1'b0;
        g_wr       = 1'b0;
        TX_MI_ADDR = '0;
        TX_MI_DWR  = '0;
        TX_MI_BE   = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q == IW'(i)) begin
                g_rd       = RX_MI_RD[i];
                g_wr       = RX_MI_WR[i];
                TX_MI_ADDR = RX_MI_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                TX_MI_DWR  = RX_MI_DWR[i*DATA_WIDTH +: DATA_WIDTH];
                TX_MI_BE   = RX_MI_BE[i*BW +: BW];
            end
        end
    end

    // A master asserting RD and WR together gets only the write forwarded.
    assign TX_MI_WR  = busy & g_wr;
    assign TX_MI_RD  = busy & g_rd & ~g_wr & ~fifo_full;
    assign accept    = TX_MI_ARDY & (TX_MI_RD | TX_MI_WR);
    assign push      = TX_MI_RD & TX_MI_ARDY;
    assign pop       = TX_MI_DRDY & ~fifo_empty;
    assign RX_MI_DRD = TX_MI_DRD;
    assign ERR_UNEXP_DRDY = err_q;

    always_comb begin
        RX_MI_ARDY = '0;
        RX_MI_DRDY = '0;
        for (int i = 0; i < MASTERS; i++) begin
            RX_MI_ARDY[i] = accept & (grant_q == IW'(i));
            RX_MI_DRDY[i] = pop & (head == IW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        unique case (state_q)
            IDLE: begin
                for (int k = 0; k < MASTERS; k++) begin
                    if (!found && req[(int'(ptr_q) + k) % MASTERS]) begin
                        found   = 1'b1;
                        grant_d = IW'((int'(ptr_q) + k) % MASTERS);
                    end
                end
                if (found) state_d = BUSY;
            end
            BUSY: begin
                if (accept) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == IW'(MASTERS - 1)) ? '0 : grant_q + 1'b1;
                end else if (!g_rd && !g_wr) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (push) wr_q <= nxt(wr_q);
            if (pop)  rd_q <= nxt(rd_q);
            if (TX_MI_DRDY && fifo_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_q[wr_q] <= grant_q;
    end

endmodule

// File: tb/tb_mi_rr_arbiter.sv
// Randomised and directed checks of mi_rr_arbiter against a queue-based
// transaction model of the arbitration and response routing rules.
module tb_mi_rr_arbiter;

    localparam int M  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [M*DW-1:0] rx_dwr = '0;
    logic [M*AW-1:0] rx_addr = '0;
    logic [M*BW-1:0] rx_be = '0;
    logic [M-1:0]    rx_rd = '0;
    logic [M-1:0]    rx_wr = '0;
    logic [M-1:0]    rx_ardy, rx_drdy;
    logic [DW-1:0]   rx_drd, tx_dwr;
    logic [AW-1:0]   tx_addr;
    logic [BW-1:0]   tx_be;
    logic            tx_rd, tx_wr, err;
    logic            tx_ardy = 1'b0;
    logic [DW-1:0]   tx_drd = '0;
    logic            tx_drdy = 1'b0;

    int total = 0;
    int bad = 0;

    bit           m_busy;
    int           m_grant;
    int           m_ptr;
    int           m_q[$];
    bit           m_err;
    logic [M-1:0] m_last_ardy;

    mi_rr_arbiter #(
        .MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .CLK(clk), .RESET_N(rst_n),
        .RX_MI_DWR(rx_dwr), .RX_MI_ADDR(rx_addr), .RX_MI_BE(rx_be),
        .RX_MI_RD(rx_rd), .RX_MI_WR(rx_wr), .RX_MI_ARDY(rx_ardy),
        .RX_MI_DRD(rx_drd), .RX_MI_DRDY(rx_drdy),
        .TX_MI_DWR(tx_dwr), .TX_MI_ADDR(tx_addr), .TX_MI_BE(tx_be),
        .TX_MI_RD(tx_rd), .TX_MI_WR(tx_wr), .TX_MI_ARDY(tx_ardy),
        .TX_MI_DRD(tx_drd), .TX_MI_DRDY(tx_drdy),
        .ERR_UNEXP_DRDY(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic eval_model(output logic erd, output logic ewr,
                              output logic [M-1:0] eardy,
                              output logic [M-1:0] edrdy);
        erd = 1'b0;
        ewr = 1'b0;
        eardy = '0;
        edrdy = '0;
        if (rst_n === 1'b1) begin
            if (m_busy) begin
                ewr = rx_wr[m_grant];
                erd = rx_rd[m_grant] && !rx_wr[m_grant] && (m_q.size() < MO);
                if (tx_ardy && (erd || ewr)) eardy[m_grant] = 1'b1;
            end
            if (tx_drdy && m_q.size() > 0) edrdy[m_q[0]] = 1'b1;
        end
    endtask

    initial begin
        logic erd, ewr;
        logic [M-1:0] ea, ed;
        int tmp;
        bit empty0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0;
                m_grant = 0;
                m_ptr = 0;
                m_q.delete();
                m_err = 0;
                m_last_ardy = '0;
            end else begin
                eval_model(erd, ewr, ea, ed);
                m_last_ardy = ea;
                empty0 = (m_q.size() == 0);
                if (tx_drdy && empty0) m_err = 1;
                if (ed != '0) tmp = m_q.pop_front();
                if (m_busy) begin
                    if (ea != '0) begin
                        if (erd) m_q.push_back(m_grant);
                        m_busy = 0;
                        m_ptr = (m_grant + 1) % M;
                    end else if (!rx_rd[m_grant] && !rx_wr[m_grant]) begin
                        m_busy = 0;
                    end
                end else begin
                    for (int k = 0; k < M; k++) begin
                        int idx;
                        idx = (m_ptr + k) % M;
                        if (!m_busy && (rx_rd[idx] || rx_wr[idx])) begin
                            m_busy = 1;
                            m_grant = idx;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic erd, ewr;
        logic [M-1:0] ea, ed;
        forever begin
            @(negedge clk);
            eval_model(erd, ewr, ea, ed);
            check("tx_rd", tx_rd, erd);
            check("tx_wr", tx_wr, ewr);
            check("rx_ardy", rx_ardy, ea);
            check("rx_drdy", rx_drdy, ed);
            check("rx_drd", rx_drd, tx_drd);
            check("err", err, m_err);
            if (m_busy && rst_n) begin
                check("tx_addr", tx_addr, rx_addr[m_grant*AW +: AW]);
                check("tx_dwr", tx_dwr, rx_dwr[m_grant*DW +: DW]);
                check("tx_be", tx_be, rx_be[m_grant*BW +: BW]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rx_rd[i] = r;
        rx_wr[i] = w;
        rx_addr[i*AW +: AW] = a;
        rx_dwr[i*DW +: DW] = d;
        rx_be[i*BW +: BW] = BW'(i + 5);
    endtask

    task automatic do_reset();
        rx_rd = '0;
        rx_wr = '0;
        tx_ardy = 0;
        tx_drdy = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        logic [M-1:0] e;
        do_reset();
        @(negedge clk);
        check("reset_err", err, 0);
        check("reset_drdy", rx_drdy, 0);

        // single read from master 1
        tick();
        set_m(1, 1, 0, 32'h40, 0);
        tx_ardy = 1;
        @(negedge clk);
        check("t1_rd_idle", tx_rd, 0);
        tick();
        @(negedge clk);
        check("t1_rd", tx_rd, 1);
        check("t1_addr", tx_addr, 32'h40);
        check("t1_ardy", rx_ardy, 3'b010);
        tick();
        set_m(1, 0, 0, 32'h40, 0);
        tick();
        tick();
        tx_drdy = 1;
        tx_drd = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_drdy", rx_drdy, 3'b010);
        check("t1_drd", rx_drd, 32'hDEADBEEF);
        tick();
        tx_drdy = 0;

        // continuous writes from all masters
        do_reset();
        for (int i = 0; i < M; i++) set_m(i, 0, 1, 32'h100 + i, 32'h55 + i);
        tx_ardy = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = (k % 2 == 1) ? M'(1 << ((k / 2) % M)) : '0;
            check("t2_ardy", rx_ardy, e);
            check("t2_wr", tx_wr, k % 2);
            if (k % 2 == 1) check("t2_addr", tx_addr, 32'h100 + (k / 2) % M);
            tick();
        end
        rx_wr = '0;

        // FIFO full back-pressure, four reads from master 0
        do_reset();
        set_m(0, 1, 0, 32'h80, 0);
        tx_ardy = 1;
        for (int k = 0; k < 14; k++) begin
            tx_drdy = (k == 9 || k >= 11);
            if (k == 11) rx_rd[0] = 0;
            @(negedge clk);
            e = (k == 1 || k == 3 || k == 5 || k == 10) ? 3'b001 : 3'b000;
            check("t3_rd", tx_rd, e[0]);
            check("t3_ardy", rx_ardy, e);
            e = (k == 9 || k >= 11) ? 3'b001 : 3'b000;
            check("t3_drdy", rx_drdy, e);
            tick();
        end
        tx_drdy = 0;

        // reads from 2, 0, 1 then back-to-back responses
        do_reset();
        tx_ardy = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) set_m(2, 1, 0, 32'h20, 0);
            if (k == 2) begin set_m(2, 0, 0, 0, 0); set_m(0, 1, 0, 32'h24, 0); end
            if (k == 4) begin set_m(0, 0, 0, 0, 0); set_m(1, 1, 0, 32'h28, 0); end
            if (k == 6) set_m(1, 0, 0, 0, 0);
            tx_drdy = (k >= 6 && k <= 8);
            tx_drd = 32'hA000 + k;
            @(negedge clk);
            unique case (k)
                1: e = 3'b100;
                3: e = 3'b001;
                5: e = 3'b010;
                default: e = 3'b000;
            endcase
            check("t4_ardy", rx_ardy, e);
            unique case (k)
                6: e = 3'b100;
                7: e = 3'b001;
                8: e = 3'b010;
                default: e = 3'b000;
            endcase
            check("t4_drdy", rx_drdy, e);
            tick();
        end
        tx_drdy = 0;

        // randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < M; i++) begin
                if (m_last_ardy[i]) begin
                    rx_rd[i] = 0;
                    rx_wr[i] = 0;
                end else if ((rx_rd[i] | rx_wr[i]) && $urandom_range(0, 40) == 0) begin
                    rx_rd[i] = 0;
                    rx_wr[i] = 0;
                end
                if (!(rx_rd[i] | rx_wr[i]) && $urandom_range(0, 3) == 0) begin
                    int t;
                    t = $urandom_range(0, 15);
                    set_m(i, (t < 8) || (t == 0), (t >= 8) || (t == 0),
                          $urandom, $urandom);
                    rx_be[i*BW +: BW] = BW'($urandom);
                end
            end
            tx_ardy = ($urandom_range(0, 3) != 0);
            tx_drd = $urandom;
            tx_drdy = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            tick();
        end

        // unexpected DRDY
        do_reset();
        tx_drdy = 1;
        @(negedge clk);
        check("t5_drdy", rx_drdy, 0);
        check("t5_err_now", err, 0);
        tick();
        tx_drdy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_err_sticky", err, 1);
            tick();
        end

        // reset with reads outstanding and master 1 granted
        do_reset();
        set_m(0, 1, 0, 32'h10, 0);
        tx_ardy = 1;
        tick();
        tick();
        set_m(0, 0, 0, 0, 0);
        set_m(2, 1, 0, 32'h14, 0);
        tick();
        tick();
        set_m(2, 0, 0, 0, 0);
        set_m(1, 1, 0, 32'h18, 0);
        tx_ardy = 0;
        tick();
        @(negedge clk);
        check("t6_busy_rd", tx_rd, 1);
        tick();
        rst_n = 0;
        tx_ardy = 1;
        tx_drdy = 1;
        @(negedge clk);
        check("t6_rst_rd", tx_rd, 0);
        check("t6_rst_wr", tx_wr, 0);
        check("t6_rst_ardy", rx_ardy, 0);
        check("t6_rst_drdy", rx_drdy, 0);
        check("t6_rst_err", err, 0);
        tick();
        rx_rd = '0;
        tx_drdy = 0;
        tx_ardy = 0;
        rst_n = 1;
        tick();
        tx_drdy = 1;
        @(negedge clk);
        check("t6_stale_drdy", rx_drdy, 0);
        tick();
        tx_drdy = 0;
        set_m(1, 1, 0, 32'h44, 0);
        tx_ardy = 1;
        tick();
        @(negedge clk);
        check("t6_fresh_ardy", rx_ardy, 3'b010);
        tick();
        set_m(1, 0, 0, 0, 0);
        tx_ardy = 0;
        tick();
        tx_drdy = 1;
        tx_drd = 32'h12345678;
        @(negedge clk);
        check("t6_fresh_drdy", rx_drdy, 3'b010);
        check("t6_fresh_drd", rx_drd, 32'h12345678);
        tick();
        tx_drdy = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
